// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART transmitter with a small byte FIFO. Bytes pushed from
//            the bus side are queued, then serialised LSB first on txd using
//            an external oversampling tick (TICKS_PER_BIT ticks per bit).
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high reset
//            tick       - one-cycle baud enable pulse (TICKS_PER_BIT x baud)
//            tx_data    - byte to queue
//            tx_valid   - tx_data valid; accepted when tx_ready is also high
//            tx_ready   - FIFO has room for another byte
//            txd        - serial line, idle high, registered
//            busy       - serialiser is sending a frame
//            fifo_level - bytes queued, not counting the byte being shifted
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int TICKS_PER_BIT = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TICKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] c_FULL      = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]         bit_cnt_q,  bit_cnt_d;
    logic [7:0]         shreg_q,    shreg_d;
    logic               txd_q,      txd_d;
    logic               busy_q,     busy_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]   level_q,    level_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    // Combinational helpers
    logic               w_push;
    logic               w_pop;
    logic               w_tick_end;
    logic               w_have;

    assign tx_ready   = (level_q != c_FULL);
    assign fifo_level = level_q;
    assign txd        = txd_q;
    assign busy       = busy_q;

    always_comb begin
        w_push     = tx_valid && tx_ready;
        w_tick_end = tick && (tick_cnt_q == c_TICK_LAST);
        // The serialiser only sees registered level, so a push is not
        // poppable until the following cycle (no bypass).
        w_have     = (level_q != '0);
        w_pop      = 1'b0;

        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (w_have) begin
                        w_pop      = 1'b1;
                        shreg_d    = mem_q[rd_ptr_q];
                        txd_d      = 1'b0;
                        tick_cnt_d = '0;
                        state_d    = S_START;
                    end
                end
                S_START: begin
                    if (w_tick_end) begin
                        txd_d      = shreg_q[0];
                        shreg_d    = {1'b0, shreg_q[7:1]};
                        bit_cnt_d  = 3'd0;
                        tick_cnt_d = '0;
                        state_d    = S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick_end) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            txd_d   = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            txd_d     = shreg_q[0];
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick_end) begin
                        tick_cnt_d = '0;
                        // Chain straight into the next start bit when more
                        // data is queued, so frames leave with no idle gap.
                        if (w_have) begin
                            w_pop   = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                            txd_d   = 1'b0;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);

        // FIFO bookkeeping; pointers wrap naturally (depth is a power of two)
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = tx_data;
        end
        wr_ptr_d = wr_ptr_q + (w_push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (w_pop  ? PTR_W'(1) : PTR_W'(0));
        level_d  = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: the cleared level/pointers make it unreadable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. A line monitor decodes txd at
//            tick resolution into 10-bit frames and compares each decoded
//            byte against a queue of bytes the bench expects to be sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int T = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;

    int   n_vec = 0;
    int   n_err = 0;
    bit   tick_en = 1'b1;
    int   tick_period = 3;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         tick_idx;
    bit         mon_active;
    int         mon_n;
    logic       prev_txd;
    logic       samples [0:10*T-1];
    int         busy_cycles;

    uart_tx #(.TICKS_PER_BIT(T), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Baud tick source: one pulse every tick_period clocks while enabled
    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!tick_en) begin
                tick = 1'b0;
                tcnt = 0;
            end else if (tcnt >= tick_period - 1) begin
                tick = 1'b1;
                tcnt = 0;
            end else begin
                tick = 1'b0;
                tcnt++;
            end
        end
    end

    // Line monitor: one sample per tick, 10*T samples per 8N1 frame
    initial begin : monitor
        logic       t;
        logic       r0;
        logic [7:0] b;
        bit         grp_ok;
        prev_txd   = 1'b1;
        mon_active = 1'b0;
        mon_n      = 0;
        tick_idx   = 0;
        forever begin
            @(posedge clk);
            t  = tick;
            r0 = reset;
            @(negedge clk);
            if (reset || r0) begin
                mon_active = 1'b0;
                mon_n      = 0;
            end else if (!t) begin
                check("txd_hold", {31'd0, txd}, {31'd0, prev_txd});
            end else begin
                tick_idx++;
                if (!mon_active && txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_n      = 0;
                    start_q.push_back(tick_idx);
                    check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                end
                if (mon_active) begin
                    samples[mon_n] = txd;
                    mon_n++;
                    if (mon_n == 10*T) begin
                        grp_ok = 1'b1;
                        for (int g = 0; g < 10; g++)
                            for (int k = 1; k < T; k++)
                                if (samples[g*T+k] !== samples[g*T]) grp_ok = 1'b0;
                        check("bit_width", {31'd0, grp_ok}, 32'd1);
                        check("stop_bit", {31'd0, samples[9*T]}, 32'd1);
                        for (int i = 0; i < 8; i++) b[i] = samples[(i+1)*T];
                        if (exp_q.size() != 0) check("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
                        mon_active = 1'b0;
                        mon_n      = 0;
                    end
                end
            end
            prev_txd = txd;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Push bytes on consecutive cycles; each must be accepted
    task automatic push_all(input logic [7:0] bs[$]);
        foreach (bs[i]) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b1;
            tx_data  = bs[i];
            check("ready_at_push", {31'd0, tx_ready}, 32'd1);
            exp_q.push_back(bs[i]);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        busy_cycles = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && !mon_active) && c < budget) begin
            @(negedge clk);
            c++;
            if (busy === 1'b1) busy_cycles++;
        end
        check(tag, {31'd0, c < budget}, 32'd1);
    endtask

    initial begin : main
        logic [7:0] v[$];
        logic [7:0] full_bytes[6];
        int         idx0;
        int         c;
        int         nb;
        int         gap;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd",      {31'd0, txd},      32'd1);
        check("rst_ready",    {31'd0, tx_ready}, 32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_level",    {29'd0, fifo_level}, 32'd0);
        @(posedge clk); #2; reset = 1'b0;

        // Single byte 0x55, tick every 3 clk: frame lasts 40 ticks = 120 clk
        tick_period = 3;
        v = '{8'h55};
        push_all(v);
        wait_done("single_done", 3000);
        check("single_busy_cycles", busy_cycles, 32'd120);
        check("single_txd_idle", {31'd0, txd}, 32'd1);

        // Back-to-back frames with no gap
        tick_period = 2;
        start_q.delete();
        v = '{8'hA3, 8'h0F};
        push_all(v);
        wait_done("b2b_done", 3000);
        check("b2b_frames", start_q.size(), 32'd2);
        if (start_q.size() >= 2) check("b2b_gap", start_q[1] - start_q[0], 32'd40);

        // FIFO full: 1 shifting + 4 queued, 6th byte dropped
        tick_period = 1;
        start_q.delete();
        for (int i = 0; i < 6; i++) full_bytes[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b1;
            tx_data  = full_bytes[i];
            if (i < 5) begin
                check("full_ready_push", {31'd0, tx_ready}, 32'd1);
                exp_q.push_back(full_bytes[i]);
            end else begin
                check("full_ready_low", {31'd0, tx_ready}, 32'd0);
                check("full_level", {29'd0, fifo_level}, 32'd4);
            end
        end
        @(posedge clk); #1; tx_valid = 1'b0;
        wait_done("full_done", 5000);
        check("full_frames", start_q.size(), 32'd5);

        // "OK\n" then 0xFF
        tick_period = 4;
        v = '{8'h4F, 8'h4B, 8'h0A, 8'hFF};
        push_all(v);
        wait_done("ok_done", 5000);

        // No tick: byte stays queued, frame starts on the first tick after
        @(posedge clk); #1; tick_en = 1'b0;
        v = '{8'h12};
        push_all(v);
        repeat (1000) @(negedge clk);
        check("notick_txd",   {31'd0, txd},        32'd1);
        check("notick_level", {29'd0, fifo_level}, 32'd1);
        check("notick_busy",  {31'd0, busy},       32'd0);
        start_q.delete();
        idx0 = tick_idx;
        tick_period = 3;
        @(posedge clk); #1; tick_en = 1'b1;
        wait_done("notick_done", 3000);
        check("notick_frames", start_q.size(), 32'd1);
        if (start_q.size() >= 1) check("notick_start", start_q[0], idx0 + 1);

        // Reset during data bit 3 of 0x00 with a second byte queued
        tick_period = 2;
        v = '{8'h00, 8'h5A};
        push_all(v);
        c = 0;
        while (!(mon_active && mon_n >= 18) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_reach", {31'd0, c < 2000}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_txd",   {31'd0, txd},        32'd1);
        check("rst_mid_busy",  {31'd0, busy},       32'd0);
        check("rst_mid_level", {29'd0, fifo_level}, 32'd0);
        check("rst_mid_ready", {31'd0, tx_ready},   32'd1);
        repeat (3) @(posedge clk);
        #2; reset = 1'b0;
        start_q.delete();
        repeat (300) @(negedge clk);
        check("post_rst_frames", start_q.size(), 32'd0);
        check("post_rst_txd",  {31'd0, txd},  32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Randomised bursts with random tick rate and push spacing
        for (int it = 0; it < 8; it++) begin
            tick_period = int'($urandom_range(1, 4));
            nb = int'($urandom_range(1, 4));
            for (int j = 0; j < nb; j++) begin
                gap = int'($urandom_range(0, 2));
                @(posedge clk);
                #1;
                tx_valid = 1'b1;
                tx_data  = (it == 3 && j == 0) ? 8'hFF : 8'($urandom);
                check("rnd_ready_push", {31'd0, tx_ready}, 32'd1);
                exp_q.push_back(tx_data);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                repeat (gap) @(posedge clk);
            end
            wait_done("rnd_done", 4000);
        end

        check("end_txd",   {31'd0, txd},        32'd1);
        check("end_busy",  {31'd0, busy},       32'd0);
        check("end_level", {29'd0, fifo_level}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
